// File: rtl/fir_xifu_ex.sv
// fir_xifu_ex: execute stage for FIR XIFU loads/stores and int16x2 dot-product with registered writeback
module fir_xifu_ex #(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [1:0]            id_instr_i,
  input  logic [31:0]           id_base_i,
  input  logic [31:0]           id_offset_i,
  input  logic [4:0]            id_shamt_i,
  input  logic [4:0]            id_rs1_i,
  input  logic [4:0]            id_rs2_i,
  input  logic [4:0]            id_rd_i,
  input  logic [X_ID_WIDTH-1:0] id_id_i,
  output logic                  ready_o,
  output logic [4:0]            rf_raddr_a_o,
  output logic [4:0]            rf_raddr_b_o,
  output logic [4:0]            rf_raddr_c_o,
  input  logic [31:0]           rf_rdata_a_i,
  input  logic [31:0]           rf_rdata_b_i,
  input  logic [31:0]           rf_rdata_c_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  output logic [X_ID_WIDTH-1:0] mem_id_o,
  input  logic                  mem_result_valid_i,
  input  logic [31:0]           mem_result_rdata_i,
  input  logic                  mem_result_err_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  wb_core_we_o,
  output logic [4:0]            wb_core_rd_o,
  output logic [31:0]           wb_core_data_o,
  output logic                  wb_x_we_o,
  output logic [4:0]            wb_x_rd_o,
  output logic [31:0]           wb_x_data_o,
  output logic [X_ID_WIDTH-1:0] wb_id_o,
  output logic                  wb_err_o
);
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RESP, OUT} state_t;
  state_t state, state_nx;
  logic [1:0] instr_q;
  logic [31:0] base_q, offset_q, wdata_q, op_a, op_b, op_c;
  logic [4:0] rs1_q, rd_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic accept, byp_ok, resp;
  logic signed [31:0] p0, p1, sw_data;
  assign ready_o = (state == IDLE) | ((state == OUT) & wb_ready_i);
  assign accept = ready_o & (id_instr_i != 2'd0);
  assign resp = (state == MEM_RESP) & mem_result_valid_i;
  assign rf_raddr_a_o = id_rs1_i;
  assign rf_raddr_b_o = id_rs2_i;
  assign rf_raddr_c_o = id_rd_i;
  // forward the pending writeback record so a dependent instruction sees it at accept
  assign byp_ok = wb_valid_o & wb_x_we_o;
  assign op_a = (byp_ok & (wb_x_rd_o == id_rs1_i)) ? wb_x_data_o : rf_rdata_a_i;
  assign op_b = (byp_ok & (wb_x_rd_o == id_rs2_i)) ? wb_x_data_o : rf_rdata_b_i;
  assign op_c = (byp_ok & (wb_x_rd_o == id_rd_i)) ? wb_x_data_o : rf_rdata_c_i;
  assign p0 = $signed({{16{op_a[15]}}, op_a[15:0]}) * $signed({{16{op_b[15]}}, op_b[15:0]});
  assign p1 = $signed({{16{op_a[31]}}, op_a[31:16]}) * $signed({{16{op_b[31]}}, op_b[31:16]});
  assign sw_data = $signed(op_b) >>> id_shamt_i;
  assign mem_valid_o = (state == MEM_REQ);
  assign mem_addr_o = base_q;
  assign mem_we_o = (instr_q == 2'd2);
  assign mem_be_o = {4{(instr_q == 2'd1) | (instr_q == 2'd2)}};
  assign mem_wdata_o = wdata_q;
  assign mem_id_o = id_q;
  assign wb_valid_o = (state == OUT);
  always_comb begin
    state_nx = accept ? ((id_instr_i == 2'd3) ? OUT : MEM_REQ) :
               ((state == OUT) & wb_ready_i) ? IDLE :
               ((state == MEM_REQ) & mem_ready_i) ? MEM_RESP :
               resp ? OUT : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      instr_q <= 2'd0;
      base_q <= '0;
      offset_q <= '0;
      wdata_q <= '0;
      rs1_q <= '0;
      rd_q <= '0;
      id_q <= '0;
      wb_core_we_o <= 1'b0;
      wb_core_rd_o <= '0;
      wb_core_data_o <= '0;
      wb_x_we_o <= 1'b0;
      wb_x_rd_o <= '0;
      wb_x_data_o <= '0;
      wb_id_o <= '0;
      wb_err_o <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= id_instr_i;
        base_q <= id_base_i;
        offset_q <= id_offset_i;
        wdata_q <= sw_data;
        rs1_q <= id_rs1_i;
        rd_q <= id_rd_i;
        id_q <= id_id_i;
      end
      if (accept & (id_instr_i == 2'd3)) begin
        wb_core_we_o <= 1'b0;
        wb_core_rd_o <= '0;
        wb_core_data_o <= '0;
        wb_x_we_o <= 1'b1;
        wb_x_rd_o <= id_rd_i;
        wb_x_data_o <= op_c + p0 + p1;
        wb_id_o <= id_id_i;
        wb_err_o <= 1'b0;
      end
      if (resp) begin
        wb_core_we_o <= ~mem_result_err_i;
        wb_core_rd_o <= rs1_q;
        wb_core_data_o <= base_q + offset_q;
        wb_x_we_o <= (instr_q == 2'd1) & ~mem_result_err_i;
        wb_x_rd_o <= rd_q;
        wb_x_data_o <= mem_result_rdata_i;
        wb_id_o <= id_q;
        wb_err_o <= mem_result_err_i;
      end
    end
  end
endmodule

// File: tb/tb_fir_xifu_ex.sv
// tb_fir_xifu_ex: vector table plus scoreboard of expected writeback records
module tb_fir_xifu_ex;
  logic clk = 0, rst_i = 1, clear_i = 0;
  logic [1:0] id_instr_i = 0;
  logic [31:0] id_base_i = 0, id_offset_i = 0;
  logic [4:0] id_shamt_i = 0, id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
  logic [3:0] id_id_i = 0;
  logic ready_o, mem_valid_o, mem_we_o, wb_valid_o, wb_core_we_o, wb_x_we_o, wb_err_o;
  logic [4:0] rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o, wb_core_rd_o, wb_x_rd_o;
  logic [31:0] rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i, mem_addr_o, mem_wdata_o;
  logic [31:0] wb_core_data_o, wb_x_data_o;
  logic [3:0] mem_be_o, mem_id_o, wb_id_o;
  logic mem_ready_i = 0, mem_result_valid_i = 0, mem_result_err_i = 0, wb_ready_i = 0;
  logic [31:0] mem_result_rdata_i = 0;
  logic [31:0] rf [32];
  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic core_we; logic [4:0] core_rd; logic [31:0] core_data;
    logic x_we; logic [4:0] x_rd; logic [31:0] x_data;
    logic [3:0] id; logic err;
  } rec_t;
  typedef struct {logic [31:0] a, b, c, exp;} dv_t;
  rec_t sb[$];
  dv_t tbl[6];

  assign rf_rdata_a_i = rf[rf_raddr_a_o];
  assign rf_rdata_b_i = rf[rf_raddr_b_o];
  assign rf_rdata_c_i = rf[rf_raddr_c_o];

  fir_xifu_ex #(.X_ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .id_instr_i(id_instr_i), .id_base_i(id_base_i), .id_offset_i(id_offset_i),
    .id_shamt_i(id_shamt_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_id_i(id_id_i), .ready_o(ready_o),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_raddr_c_o(rf_raddr_c_o),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
    .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i),
    .mem_result_err_i(mem_result_err_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_core_we_o(wb_core_we_o), .wb_core_rd_o(wb_core_rd_o), .wb_core_data_o(wb_core_data_o),
    .wb_x_we_o(wb_x_we_o), .wb_x_rd_o(wb_x_rd_o), .wb_x_data_o(wb_x_data_o),
    .wb_id_o(wb_id_o), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // fields behind a cleared write enable are unspecified, so they are not compared
  function automatic rec_t norm(input rec_t r);
    if (!r.core_we) begin r.core_rd = 0; r.core_data = 0; end
    if (!r.x_we) begin r.x_rd = 0; r.x_data = 0; end
    return r;
  endfunction

  function automatic rec_t mk(input logic cwe, input logic [4:0] crd, input logic [31:0] cd,
                              input logic xwe, input logic [4:0] xrd, input logic [31:0] xd,
                              input logic [3:0] id, input logic err);
    rec_t r;
    r = '{core_we:cwe, core_rd:crd, core_data:cd, x_we:xwe, x_rd:xrd, x_data:xd, id:id, err:err};
    return r;
  endfunction

  always @(negedge clk) begin
    if (wb_valid_o && wb_ready_i) begin
      rec_t got, exp;
      got = norm({wb_core_we_o, wb_core_rd_o, wb_core_data_o, wb_x_we_o, wb_x_rd_o,
                  wb_x_data_o, wb_id_o, wb_err_o});
      n_chk++;
      if (sb.size() == 0) $display("FAIL wb_unexpected: got %h expected none", got);
      else begin
        exp = norm(sb.pop_front());
        if (got === exp) n_pass++;
        else $display("FAIL wb_record: got %h expected %h", got, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ins, input logic [31:0] base, off, input logic [4:0] sh,
                       input logic [4:0] r1, r2, rd, input logic [3:0] id);
    tick();
    id_instr_i = ins; id_base_i = base; id_offset_i = off; id_shamt_i = sh;
    id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd; id_id_i = id;
    @(negedge clk);
    chk("issue_ready", {63'd0, ready_o}, 64'd1);
    tick();
    id_instr_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0002_FFFF, 32'h0003_0004, 32'd10, 32'd12};
    tbl[1] = '{32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'd0, 32'h7FFE_0002};
    tbl[2] = '{32'h8000_8000, 32'h8000_8000, 32'd0, 32'h8000_0000};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0005_0003, 32'h100, 32'hF8};
    tbl[4] = '{32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[5] = '{32'h0001_0001, 32'h0001_0001, 32'hFFFF_FFFF, 32'h1};
    for (int i = 0; i < 32; i++) rf[i] = 0;
    repeat (3) tick();
    rst_i = 0;
    @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_valids", {62'd0, mem_valid_o, wb_valid_o}, 64'd0);
    chk("rst_mem", {mem_addr_o, mem_wdata_o}, 64'd0);
    chk("rst_mem_ctl", {55'd0, mem_we_o, mem_be_o, mem_id_o}, 64'd0);
    chk("rst_wb_en", {59'd0, wb_core_we_o, wb_x_we_o, wb_err_o, 2'd0}, 64'd0);
    chk("rst_wb_data", {wb_core_data_o, wb_x_data_o}, 64'd0);
    chk("rst_wb_idx", {50'd0, wb_core_rd_o, wb_x_rd_o, wb_id_o}, 64'd0);
    // back-to-back dot products, one record per cycle
    wb_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      rf[1] = tbl[i].a; rf[2] = tbl[i].b; rf[20+i] = tbl[i].c;
      id_instr_i = 3; id_rs1_i = 1; id_rs2_i = 2; id_rd_i = 5'(20 + i); id_id_i = 4'(i);
      sb.push_back(mk(0, 0, 0, 1, 5'(20 + i), tbl[i].exp, 4'(i), 0));
      @(negedge clk);
      chk("dotp_ready", {63'd0, ready_o}, 64'd1);
      if (i > 0) chk("dotp_stream_valid", {63'd0, wb_valid_o}, 64'd1);
    end
    tick();
    id_instr_i = 0;
    @(negedge clk);
    chk("dotp_last_valid", {63'd0, wb_valid_o}, 64'd1);
    tick();
    @(negedge clk);
    chk("dotp_drain", {63'd0, wb_valid_o}, 64'd0);
    // load with delayed mem_ready
    issue(1, 32'h1000, 32'd4, 0, 3, 0, 7, 5);
    sb.push_back(mk(1, 3, 32'h1004, 1, 7, 32'hDEAD_BEEF, 5, 0));
    @(negedge clk);
    chk("lw_req", {mem_valid_o, mem_we_o, mem_be_o, mem_id_o, 22'd0, mem_addr_o}, {1'b1, 1'b0, 4'hF, 4'd5, 22'd0, 32'h1000});
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) mem_ready_i = 1;
      @(negedge clk);
      chk("lw_req_hold", {mem_valid_o, mem_we_o, mem_be_o, mem_id_o, 22'd0, mem_addr_o}, {1'b1, 1'b0, 4'hF, 4'd5, 22'd0, 32'h1000});
    end
    tick();
    mem_ready_i = 0; mem_result_valid_i = 1; mem_result_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lw_resp_phase", {62'd0, mem_valid_o, wb_valid_o}, 64'd0);
    tick();
    mem_result_valid_i = 0;
    @(negedge clk);
    chk("lw_wb_valid", {63'd0, wb_valid_o}, 64'd1);
    // store with shift and base wrap; exact N+3 latency
    rf[2] = 32'h8000_0000;
    issue(2, 32'hFFFF_FFFC, 32'd8, 4, 4, 2, 0, 3);
    sb.push_back(mk(1, 4, 32'h4, 0, 0, 0, 3, 0));
    mem_ready_i = 1;
    @(negedge clk);
    chk("sw_req", {mem_valid_o, mem_we_o, mem_be_o, 26'd0, mem_wdata_o}, {1'b1, 1'b1, 4'hF, 26'd0, 32'hF800_0000});
    tick();
    mem_ready_i = 0; mem_result_valid_i = 1; mem_result_rdata_i = 0;
    @(negedge clk);
    chk("sw_n2_no_wb", {63'd0, wb_valid_o}, 64'd0);
    tick();
    mem_result_valid_i = 0;
    @(negedge clk);
    chk("sw_n3_wb", {63'd0, wb_valid_o}, 64'd1);
    // load returning an error
    issue(1, 32'h2000, 32'd4, 0, 3, 0, 9, 9);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 9, 1));
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0; mem_result_valid_i = 1; mem_result_err_i = 1; mem_result_rdata_i = 32'h1234;
    tick();
    mem_result_valid_i = 0; mem_result_err_i = 0;
    @(negedge clk);
    chk("err_flags", {60'd0, wb_valid_o, wb_err_o, wb_core_we_o, wb_x_we_o}, 64'b1100);
    // stalled load to x5, dependent dotp accepted as wb_ready rises
    tick();
    wb_ready_i = 0;
    rf[5] = 32'h1111_1111;
    issue(1, 32'h3000, 32'd0, 0, 3, 0, 5, 2);
    sb.push_back(mk(1, 3, 32'h3000, 1, 5, 32'h0002_0003, 2, 0));
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0; mem_result_valid_i = 1; mem_result_rdata_i = 32'h0002_0003;
    tick();
    mem_result_valid_i = 0;
    @(negedge clk);
    chk("byp_stall", {62'd0, wb_valid_o, ready_o}, 64'b10);
    tick();
    @(negedge clk);
    chk("byp_wb_stable", {31'd0, wb_valid_o, wb_x_data_o}, {31'd0, 1'b1, 32'h0002_0003});
    tick();
    wb_ready_i = 1;
    rf[6] = 32'h0004_0005; rf[8] = 32'd100;
    id_instr_i = 3; id_rs1_i = 5; id_rs2_i = 6; id_rd_i = 8; id_id_i = 4;
    sb.push_back(mk(0, 0, 0, 1, 8, 32'd123, 4, 0));
    @(negedge clk);
    chk("byp_ready", {63'd0, ready_o}, 64'd1);
    tick();
    id_instr_i = 0;
    tick();
    // reset while waiting for the response, then a stray response
    issue(1, 32'h4000, 32'd0, 0, 3, 0, 9, 1);
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0; rst_i = 1;
    tick();
    rst_i = 0; mem_result_valid_i = 1; mem_result_rdata_i = 32'hBAD;
    tick();
    mem_result_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_drop", {61'd0, wb_valid_o, mem_valid_o, ready_o}, 64'b001);
      tick();
    end
    // clear while the request is outstanding
    issue(1, 32'h5000, 32'd0, 0, 3, 0, 9, 6);
    clear_i = 1;
    tick();
    clear_i = 0;
    @(negedge clk);
    chk("clear_drop", {61'd0, wb_valid_o, mem_valid_o, ready_o}, 64'b001);
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
